// File: rtl/multicycle_ctrl.sv
// Multi-cycle control sequencer for the single-ALU core: fetch/decode/execute FSM
// for addi and bne, immediate generation, retired-instruction counter and fault trap.
module multicycle_ctrl #(
   parameter int DATA_WIDTH  = 32,
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_WIDTH   = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   output logic                  imem_req,
   input  logic                  imem_ready,
   input  logic [DATA_WIDTH-1:0] imem_rdata,
   input  logic                  EQ,
   output logic [DATA_WIDTH-1:0] instr,
   output logic [DATA_WIDTH-1:0] imm,
   output logic                  ALUctrl,
   output logic                  RegWrite,
   output logic                  PCwrite,
   output logic                  PCsrc,
   output logic                  retire,
   output logic [CNT_WIDTH-1:0]  instret,
   output logic [1:0]            fault_code
);

   localparam int WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_EXEC_ADD,
      S_EXEC_BR,
      S_FAULT
   } state_t;

   state_t            state;
   state_t            state_next;
   logic [WAIT_W-1:0] wait_cnt;

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [4:0] rd;
   logic       is_addi;
   logic       is_bne;
   logic       fetch_timeout;

   assign opcode  = instr[6:0];
   assign funct3  = instr[14:12];
   assign rd      = instr[11:7];
   assign is_addi = (opcode == OP_IMM) && (funct3 == 3'b000);
   assign is_bne  = (opcode == OP_BRANCH) && (funct3 == 3'b001);

   // The last allowed wait cycle without ready is the one that trips the trap.
   assign fetch_timeout = (state == S_FETCH) && !imem_ready && (wait_cnt == WAIT_LAST);

   always_comb begin
      state_next = state;
      imem_req   = 1'b0;
      ALUctrl    = 1'b0;
      RegWrite   = 1'b0;
      PCwrite    = 1'b0;
      PCsrc      = 1'b0;
      retire     = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) state_next = S_FETCH;
         end
         S_FETCH: begin
            imem_req = 1'b1;
            if (imem_ready)         state_next = S_DECODE;
            else if (fetch_timeout) state_next = S_FAULT;
         end
         S_DECODE: begin
            if (is_addi)     state_next = S_EXEC_ADD;
            else if (is_bne) state_next = S_EXEC_BR;
            else             state_next = S_FAULT;
         end
         S_EXEC_ADD: begin
            RegWrite   = (rd != 5'd0);
            PCwrite    = 1'b1;
            retire     = 1'b1;
            state_next = S_FETCH;
         end
         S_EXEC_BR: begin
            ALUctrl    = 1'b1;
            PCwrite    = 1'b1;
            PCsrc      = ~EQ;
            retire     = 1'b1;
            state_next = S_FETCH;
         end
         S_FAULT: begin
            state_next = S_FAULT;
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   always_comb begin
      imm = '0;
      case (opcode)
         OP_IMM, OP_LOAD, OP_JALR: begin
            imm = {{(DATA_WIDTH-12){instr[31]}}, instr[31:20]};
         end
         OP_BRANCH: begin
            imm = {{(DATA_WIDTH-13){instr[31]}}, instr[31], instr[7],
                   instr[30:25], instr[11:8], 1'b0};
         end
         default: begin
            imm = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         instr      <= '0;
         wait_cnt   <= '0;
         instret    <= '0;
         fault_code <= 2'b00;
      end else begin
         state <= state_next;
         if ((state == S_FETCH) && imem_ready) instr <= imem_rdata;
         // Counter only runs while waiting in FETCH, so every FETCH entry starts at zero.
         if ((state == S_FETCH) && !imem_ready) wait_cnt <= wait_cnt + WAIT_W'(1);
         else                                   wait_cnt <= '0;
         if (retire) instret <= instret + CNT_WIDTH'(1);
         if (fetch_timeout)                                 fault_code <= 2'b10;
         else if ((state == S_DECODE) && !is_addi && !is_bne) fault_code <= 2'b01;
      end
   end

endmodule
